// File: rtl/pipeline_ctrl_pkg.sv
// Shared types and constants for the diag-v2 pipeline hazard/sequencing controller.
// Holds the controller state encoding, the forwarding-select encoding and a small
// helper that detects a read-after-write match against a writing stage.
package pipeline_ctrl_pkg;

  localparam int FWD_BUS_BITS = 2;

  typedef logic [FWD_BUS_BITS-1:0] fwd_sel_t;

  localparam fwd_sel_t FWD_REG = 2'b00;  // operand from register file
  localparam fwd_sel_t FWD_WB  = 2'b01;  // operand from WB result
  localparam fwd_sel_t FWD_MEM = 2'b10;  // operand from MEM-stage ALU result

  typedef enum logic [1:0] {
    CTRL_RUN        = 2'd0,
    CTRL_MEM_WAIT   = 2'd1,
    CTRL_ECALL_WAIT = 2'd2,
    CTRL_HALT       = 2'd3
  } ctrl_state_e;

  // True when a stage writing rd (x0 excluded) produces the register rs reads.
  function automatic logic raw_match(input logic we, input logic [4:0] rd, input logic [4:0] rs);
    return we & (rd != 5'd0) & (rd == rs);
  endfunction

endpackage

// File: rtl/pipeline_ctrl_if.sv
// Datapath <-> controller bundle: stage-tagged register fields, memory/ecall
// handshakes and the stall/flush/forward controls. The datapath is the master,
// the controller the slave.
interface pipeline_ctrl_if;
  logic [4:0] rs1_D, rs2_D, rs1_E, rs2_E;
  logic [4:0] rd_E, rd_M, rd_W;
  logic       regWrite_E, regWrite_M, regWrite_W;
  logic       memRead_E, pcSrc_E, ecall_W;
  logic       dmemReq_M, dmemReady, ecallDone;
  logic       stallF, stallD, stallE, stallM;
  logic       flushD, flushE, flushW;
  logic [1:0] forwardA_E, forwardB_E;
  logic       memError, halted;

  modport master (
    output rs1_D, rs2_D, rs1_E, rs2_E, rd_E, rd_M, rd_W,
    output regWrite_E, regWrite_M, regWrite_W, memRead_E, pcSrc_E, ecall_W,
    output dmemReq_M, dmemReady, ecallDone,
    input  stallF, stallD, stallE, stallM, flushD, flushE, flushW,
    input  forwardA_E, forwardB_E, memError, halted
  );

  modport slave (
    input  rs1_D, rs2_D, rs1_E, rs2_E, rd_E, rd_M, rd_W,
    input  regWrite_E, regWrite_M, regWrite_W, memRead_E, pcSrc_E, ecall_W,
    input  dmemReq_M, dmemReady, ecallDone,
    output stallF, stallD, stallE, stallM, flushD, flushE, flushW,
    output forwardA_E, forwardB_E, memError, halted
  );
endinterface

// File: rtl/pipeline_ctrl_hazard_fwd.sv
// hazard_fwd_unit: purely combinational EX-operand forwarding select for one
// operand. The MEM-stage producer is younger than the WB one, so it wins.
module hazard_fwd_unit
  import pipeline_ctrl_pkg::*;
(
  input  logic [4:0] rs_e,
  input  logic [4:0] rd_m,
  input  logic [4:0] rd_w,
  input  logic       reg_write_m,
  input  logic       reg_write_w,
  output fwd_sel_t   fwd_sel
);

  // Pick the youngest in-flight producer of rs_e, else the register file.
  always_comb begin
    fwd_sel = FWD_REG;
    if (raw_match(reg_write_m, rd_m, rs_e)) begin
      fwd_sel = FWD_MEM;
    end else if (raw_match(reg_write_w, rd_w, rs_e)) begin
      fwd_sel = FWD_WB;
    end else begin
      fwd_sel = FWD_REG;
    end
  end

endmodule

// File: rtl/pipeline_ctrl.sv
// pipeline_ctrl: hazard and sequencing controller for the diag-v2 5-stage pipeline.
// Produces zero-latency stall/flush/forward controls and runs a small FSM that
// freezes the pipeline during multi-cycle data-memory accesses and ecalls.
// Build option: define HAZARD_FORWARD_EN to enable EX forwarding; when undefined
// forwards are tied to register-file and every decode RAW hazard stalls instead.
module pipeline_ctrl
  import pipeline_ctrl_pkg::*;
#(
  parameter int unsigned MEM_TIMEOUT = 255  // 1..255 cycles in MEM_WAIT before bus error
) (
  input logic           clk,
  input logic           reset,
  pipeline_ctrl_if.slave bus
);

`ifdef HAZARD_FORWARD_EN
  localparam logic fwd_en = 1'b1;
`else
  localparam logic fwd_en = 1'b0;
`endif

  localparam logic [7:0] timeout_lim = 8'(MEM_TIMEOUT);

  ctrl_state_e state;
  logic [7:0]  wait_cnt;
  logic [7:0]  wait_inc;
  logic        ecall_pend;
  logic        mem_error;
  logic        halted;

  logic        mem_stall_run;
  logic        freeze;
  logic        decode_hazard;
  fwd_sel_t    fwd_a_raw, fwd_b_raw;

  logic        stall_f, stall_d, stall_e, stall_m;
  logic        flush_d, flush_e, flush_w;
  fwd_sel_t    fwd_a, fwd_b;

  hazard_fwd_unit u_fwd_a (
    .rs_e(bus.rs1_E), .rd_m(bus.rd_M), .rd_w(bus.rd_W),
    .reg_write_m(bus.regWrite_M), .reg_write_w(bus.regWrite_W), .fwd_sel(fwd_a_raw)
  );

  hazard_fwd_unit u_fwd_b (
    .rs_e(bus.rs2_E), .rd_m(bus.rd_M), .rd_w(bus.rd_W),
    .reg_write_m(bus.regWrite_M), .reg_write_w(bus.regWrite_W), .fwd_sel(fwd_b_raw)
  );

  // Freeze condition and decode hazard detection from current state and inputs.
  always_comb begin
    mem_stall_run = (state == CTRL_RUN) & bus.dmemReq_M & ~bus.dmemReady;
    freeze = mem_stall_run
           | ((state == CTRL_MEM_WAIT) & ~bus.dmemReady)
           | (state == CTRL_ECALL_WAIT)
           | (state == CTRL_HALT)
           | ((state == CTRL_RUN) & ecall_pend);
    // Without forwarding any in-flight producer of a decode source must be waited out.
    decode_hazard = (bus.memRead_E & (raw_match(bus.regWrite_E, bus.rd_E, bus.rs1_D)
                                    | raw_match(bus.regWrite_E, bus.rd_E, bus.rs2_D)))
                  | (~fwd_en & (raw_match(bus.regWrite_E, bus.rd_E, bus.rs1_D)
                              | raw_match(bus.regWrite_E, bus.rd_E, bus.rs2_D)
                              | raw_match(bus.regWrite_M, bus.rd_M, bus.rs1_D)
                              | raw_match(bus.regWrite_M, bus.rd_M, bus.rs2_D)));
  end

  // Stall/flush/forward controls; a freeze overrides all hazard-derived controls.
  always_comb begin
    stall_f = 1'b0;
    stall_d = 1'b0;
    stall_e = 1'b0;
    stall_m = 1'b0;
    flush_d = 1'b0;
    flush_e = 1'b0;
    flush_w = 1'b0;
    fwd_a   = FWD_REG;
    fwd_b   = FWD_REG;
    if (freeze) begin
      stall_f = 1'b1;
      stall_d = 1'b1;
      stall_e = 1'b1;
      stall_m = 1'b1;
      flush_w = 1'b1;
    end else begin
      fwd_a = fwd_en ? fwd_a_raw : FWD_REG;
      fwd_b = fwd_en ? fwd_b_raw : FWD_REG;
      if (bus.pcSrc_E) begin
        // Redirect squashes both younger instructions; holding decode would be wrong.
        flush_d = 1'b1;
        flush_e = 1'b1;
      end else if (decode_hazard) begin
        stall_f = 1'b1;
        stall_d = 1'b1;
        flush_e = 1'b1;
      end else begin
        flush_e = 1'b0;
      end
    end
  end

  // Saturating wait-counter increment; never wraps past the timeout limit.
  always_comb begin
    if (wait_cnt == timeout_lim) begin
      wait_inc = wait_cnt;
    end else begin
      wait_inc = wait_cnt + 8'd1;
    end
  end

  // Sequencing FSM with registered memError/halted flags.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= CTRL_RUN;
      wait_cnt   <= 8'd0;
      ecall_pend <= 1'b0;
      mem_error  <= 1'b0;
      halted     <= 1'b0;
    end else begin
      case (state)
        CTRL_RUN: begin
          wait_cnt <= 8'd0;
          if (mem_stall_run) begin
            state <= CTRL_MEM_WAIT;
            if (bus.ecall_W) ecall_pend <= 1'b1;
          end else if (bus.ecall_W | ecall_pend) begin
            state      <= CTRL_ECALL_WAIT;
            ecall_pend <= 1'b0;
          end
        end
        CTRL_MEM_WAIT: begin
          if (bus.ecall_W) ecall_pend <= 1'b1;
          if (bus.dmemReady) begin
            state    <= CTRL_RUN;
            wait_cnt <= 8'd0;
          end else if (wait_inc == timeout_lim) begin
            state     <= CTRL_HALT;
            wait_cnt  <= wait_inc;
            mem_error <= 1'b1;
            halted    <= 1'b1;
          end else begin
            wait_cnt <= wait_inc;
          end
        end
        CTRL_ECALL_WAIT: begin
          wait_cnt <= 8'd0;
          if (bus.ecallDone) state <= CTRL_RUN;
        end
        CTRL_HALT: begin
          wait_cnt <= 8'd0;
          halted   <= 1'b1;
        end
        default: begin
          state    <= CTRL_RUN;
          wait_cnt <= 8'd0;
        end
      endcase
    end
  end

  assign bus.stallF     = stall_f;
  assign bus.stallD     = stall_d;
  assign bus.stallE     = stall_e;
  assign bus.stallM     = stall_m;
  assign bus.flushD     = flush_d;
  assign bus.flushE     = flush_e;
  assign bus.flushW     = flush_w;
  assign bus.forwardA_E = fwd_a;
  assign bus.forwardB_E = fwd_b;
  assign bus.memError   = mem_error;
  assign bus.halted     = halted;

endmodule

// File: doc/pipeline_ctrl.md
# pipeline_ctrl

Central hazard and sequencing controller for the diag-v2 5-stage pipeline. It drives the stall and flush controls of the IF/ID, ID/EX, EX/MEM and MEM/WB pipeline registers and the EX-stage forwarding selects. It also runs a small FSM that freezes the whole pipeline during multi-cycle data-memory accesses and ecall servicing. It sits beside the datapath and takes stage-tagged register addresses and control bits from the pipeline registers.

## Interface
- MEM_TIMEOUT, 255: maximum cycles in MEM_WAIT before a bus error; must be ≥1 and fit in 8 bits.
- clk  in  1  pipeline clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-high reset.
- rs1_D, rs2_D  in  5  source registers of the instruction in decode.
- rs1_E, rs2_E  in  5  source registers of the instruction in execute.
- rd_E, rd_M, rd_W  in  5  destination registers in EX, MEM and WB.
- regWrite_E, regWrite_M, regWrite_W  in  1  register-write enables per stage.
- memRead_E  in  1  the instruction in EX is a load.
- pcSrc_E  in  1  a branch or jump is taken in EX.
- ecall_W  in  1  an ecall is in WB; pulses for 1 cycle.
- dmemReq_M  in  1  the MEM stage issues a data-memory access.
- dmemReady  in  1  data memory completes the access this cycle.
- ecallDone  in  1  the environment has finished servicing the ecall.
- stallF, stallD, stallE, stallM  out  1  hold the PC, IF/ID, ID/EX and EX/MEM registers.
- flushD, flushE, flushW  out  1  load a bubble into IF/ID, ID/EX and MEM/WB on the next edge.
- forwardA_E, forwardB_E  out  2  operand select: 00 register file, 01 WB result, 10 MEM ALU result.
- memError  out  1  sticky; set on a memory timeout.
- halted  out  1  the FSM is in HALT.

## Operation
- FSM states:
  - RUN: normal operation.
  - MEM_WAIT: waiting for data memory.
  - ECALL_WAIT: waiting for ecall servicing.
  - HALT: stopped until reset.
- freeze = (RUN & dmemReq_M & !dmemReady) | (MEM_WAIT & !dmemReady) | ECALL_WAIT | HALT | (RUN & ecallPend).
- While freeze is high:
  - stallF, stallD, stallE and stallM are 1.
  - flushD and flushE are 0.
  - flushW is 1.
  - All hazard-derived controls are suppressed.
- Transitions:
  - RUN to MEM_WAIT: dmemReq_M & !dmemReady.
  - RUN to ECALL_WAIT: (ecall_W | ecallPend) & no memory stall this cycle.
  - MEM_WAIT to RUN: dmemReady.
  - MEM_WAIT to HALT: the wait counter reaches MEM_TIMEOUT with no dmemReady; memError is set.
  - ECALL_WAIT to RUN: ecallDone.
  - HALT: stays until reset.
- ecallPend is set when ecall_W occurs while a memory stall is active, and cleared on entry to ECALL_WAIT.
- waitCnt (8 bits):
  - cleared in every state except MEM_WAIT;
  - increments each MEM_WAIT cycle;
  - saturates at MEM_TIMEOUT and never wraps.
- Load-use hazard: memRead_E & regWrite_E & rd_E≠0 & (rd_E==rs1_D | rd_E==rs2_D). Response: stallF=1, stallD=1, flushE=1.
- Taken branch: pcSrc_E=1 gives flushD=1 and flushE=1. It overrides load-use, so stallF and stallD are 0 that cycle.
- Forwarding for operand A (B is identical with rs2_E):
  - 10 if regWrite_M & rd_M≠0 & rd_M==rs1_E;
  - else 01 if regWrite_W & rd_W≠0 & rd_W==rs1_E;
  - else 00.
  - MEM takes priority over WB.

## Timing
- All stall, flush and forward outputs are combinational from the inputs and the current state, with zero-cycle latency.
- The state, waitCnt, ecallPend and memError update on the clock edge.
- Reset values:
  - state RUN; waitCnt 0; ecallPend 0;
  - memError 0; halted 0;
  - all stall and flush outputs 0; forwards 00 (given idle inputs).
- dmemReady in the same cycle as dmemReq_M: no stall, and the FSM stays in RUN.
- A MEM_WAIT lasting N cycles freezes the pipeline for exactly N cycles.
- The freeze releases in the cycle in which dmemReady is seen.
- Reset asserted mid-wait returns the FSM to RUN immediately and clears memError.

## Configuration
- HAZARD_FORWARD_EN defined: forwarding is as described above.
- HAZARD_FORWARD_EN undefined:
  - forwardA_E and forwardB_E are tied to 00.
  - Any RAW hazard on rs1_D or rs2_D against rd_E (regWrite_E) or rd_M (regWrite_M), with rd≠0, produces the load-use response (stallF, stallD, flushE).

## Structure
- Add to diagv2_const.vh:
  - state encodings CTRL_RUN, CTRL_MEM_WAIT, CTRL_ECALL_WAIT, CTRL_HALT (2 bits);
  - FWD_REG, FWD_WB, FWD_MEM;
  - FwdBusBits.
- Sub-module hazard_fwd_unit: purely combinational forwarding-select logic, instantiated twice (operand A and operand B).

## Test plan
- rd_E=5 load with rs1_D=5 → stallF=1, stallD=1, flushE=1 for 1 cycle; rd_E=0 → no stall.
- dmemReq_M with dmemReady low for 3 cycles → freeze for 3 cycles with flushW=1, then RUN.
- MEM_TIMEOUT=4 and dmemReady never asserted → HALT; memError=1 and halted=1 until reset.
- ecall_W during a memory stall → ECALL_WAIT after dmemReady; freeze until ecallDone, then RUN.
- rd_M=rd_W=7 with rs1_E=7, both writing → forwardA_E=10; with HAZARD_FORWARD_EN undefined → 00, and the decode RAW hazard stalls.
- pcSrc_E=1 together with a load-use hazard → flushD=1, flushE=1, stallD=0.
